spi_stream_arb: RTL and testbench

SPI_STREAM_ARB -- requirements
Module: spi_stream_arb

---
 rtl/spi_stream_arb.sv | 195 +++++++++++++++++++
 tb/tb_spi_stream_arb.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_stream_arb.sv
// spi_stream_arb: two-channel descriptor arbiter for a shared SPI stream engine.
// Define SPI_STREAM_ARB_PREEMPT_EN to let ch0 preempt a running ch1 transfer
// (ch1 progress is saved as a single context and resumed later).
module spi_stream_arb #(
  parameter int W_ADDR  = 22,
  parameter int W_COUNT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  input  logic [W_ADDR-1:0]  req_addr0,
  input  logic [W_ADDR-1:0]  req_addr1,
  input  logic [W_COUNT-1:0] req_count0,
  input  logic [W_COUNT-1:0] req_count1,
  output logic [1:0]         req_ready,
  output logic [1:0]         done,
  output logic               owner,
  output logic               owner_valid,
  output logic [W_ADDR-1:0]  eng_addr_o,
  output logic [W_COUNT-1:0] eng_count_o,
  output logic               eng_wen,
  input  logic [W_ADDR-1:0]  eng_addr_i,
  input  logic [W_COUNT-1:0] eng_count_i,
  output logic               eng_start,
  output logic               eng_pause_req,
  input  logic               eng_busy,
  input  logic               eng_pause_ack,
  input  logic               eng_finished,
  input  logic [1:0]         eng_flevel
);
`ifdef SPI_STREAM_ARB_PREEMPT_EN
  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, PAUSE, DRAIN, SWAP} state_e;
  logic               ctx_valid_q, ctx_valid_d;
  logic [W_ADDR-1:0]  ctx_addr_q, ctx_addr_d;
  logic [W_COUNT-1:0] ctx_count_q, ctx_count_d;
  logic               resume_q, resume_d;
  logic               ld_ctx_q, ld_ctx_d;
`else
  typedef enum logic [1:0] {IDLE, LOAD, START, RUN} state_e;
  logic unused_ok;
  assign unused_ok = ^{eng_addr_i, eng_count_i, eng_flevel};
`endif
  state_e state_q, state_d;
  logic   ld_ch_q, ld_ch_d;
  logic   owner_q, owner_d;
  logic   owner_valid_q, owner_valid_d;
  logic   wen_ok;
  assign wen_ok      = !(eng_busy && !eng_pause_ack);
  assign owner       = owner_q;
  assign owner_valid = owner_valid_q;
  // Control state, selected load source and channel ownership
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ld_ch_q       <= 1'b0;
      owner_q       <= 1'b0;
      owner_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ld_ch_q       <= ld_ch_d;
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
    end
  end
`ifdef SPI_STREAM_ARB_PREEMPT_EN
  // Saved ch1 context and whether the engine was left paused mid-transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctx_valid_q <= 1'b0;
      ctx_addr_q  <= '0;
      ctx_count_q <= '0;
      resume_q    <= 1'b0;
      ld_ctx_q    <= 1'b0;
    end else begin
      ctx_valid_q <= ctx_valid_d;
      ctx_addr_q  <= ctx_addr_d;
      ctx_count_q <= ctx_count_d;
      resume_q    <= resume_d;
      ld_ctx_q    <= ld_ctx_d;
    end
  end
`endif
  // Next-state and output decode; engine writes are held off while it runs unpaused
  always_comb begin
    state_d       = state_q;
    ld_ch_d       = ld_ch_q;
    owner_d       = owner_q;
    owner_valid_d = owner_valid_q;
    req_ready     = 2'b00;
    done          = 2'b00;
    eng_wen       = 1'b0;
    eng_start     = 1'b0;
    eng_pause_req = 1'b0;
    eng_addr_o    = '0;
    eng_count_o   = '0;
`ifdef SPI_STREAM_ARB_PREEMPT_EN
    ctx_valid_d   = ctx_valid_q;
    ctx_addr_d    = ctx_addr_q;
    ctx_count_d   = ctx_count_q;
    resume_d      = resume_q;
    ld_ctx_d      = ld_ctx_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid[0]) begin
          state_d = LOAD;
          ld_ch_d = 1'b0;
`ifdef SPI_STREAM_ARB_PREEMPT_EN
          ld_ctx_d = 1'b0;
        end else if (ctx_valid_q) begin
          state_d  = LOAD;
          ld_ch_d  = 1'b1;
          ld_ctx_d = 1'b1;
`endif
        end else if (req_valid[1]) begin
          state_d = LOAD;
          ld_ch_d = 1'b1;
`ifdef SPI_STREAM_ARB_PREEMPT_EN
          ld_ctx_d = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (wen_ok) begin
          eng_wen            = 1'b1;
          eng_addr_o         = ld_ch_q ? req_addr1 : req_addr0;
          eng_count_o        = ld_ch_q ? req_count1 : req_count0;
          req_ready[ld_ch_q] = 1'b1;
`ifdef SPI_STREAM_ARB_PREEMPT_EN
          if (ld_ctx_q) begin
            eng_addr_o  = ctx_addr_q;
            eng_count_o = ctx_count_q;
            req_ready   = 2'b00;
            ctx_valid_d = 1'b0;
          end
`endif
          owner_d       = ld_ch_q;
          owner_valid_d = 1'b1;
          state_d       = START;
        end
      end
      START: begin
        eng_start = 1'b1;
        state_d   = eng_busy ? RUN : START;
      end
      RUN: begin
        if (eng_finished) begin
          done[owner_q] = 1'b1;
          owner_d       = 1'b0;
          owner_valid_d = 1'b0;
          state_d       = IDLE;
`ifdef SPI_STREAM_ARB_PREEMPT_EN
        end else if (req_valid[0] && owner_q) begin
          state_d = PAUSE;
`endif
        end
      end
`ifdef SPI_STREAM_ARB_PREEMPT_EN
      PAUSE: begin
        eng_pause_req = 1'b1;
        if (eng_finished) begin
          done[1]  = 1'b1;
          resume_d = 1'b0;
          state_d  = DRAIN;
        end else if (eng_pause_ack) begin
          resume_d = eng_busy;
          if (eng_busy) begin
            ctx_valid_d = 1'b1;
            ctx_addr_d  = eng_addr_i;
            ctx_count_d = eng_count_i;
          end
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        eng_pause_req = 1'b1;
        state_d       = (eng_flevel == 2'd0) ? SWAP : DRAIN;
      end
      SWAP: begin
        if (wen_ok) begin
          eng_wen      = 1'b1;
          eng_addr_o   = req_addr0;
          eng_count_o  = req_count0;
          req_ready[0] = 1'b1;
          owner_d      = 1'b0;
          state_d      = resume_q ? RUN : START;
        end else begin
          eng_pause_req = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_spi_stream_arb.sv
// tb_spi_stream_arb: vector table, preemption sequences, async reset and a randomized transaction-level run.
module tb_spi_stream_arb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [21:0] req_addr0, req_addr1;
  logic [15:0] req_count0, req_count1;
  logic [1:0]  req_ready, done;
  logic        owner, owner_valid;
  logic [21:0] eng_addr_o, eng_addr_i;
  logic [15:0] eng_count_o, eng_count_i;
  logic        eng_wen, eng_start, eng_pause_req;
  logic        eng_busy, eng_pause_ack, eng_finished;
  logic [1:0]  eng_flevel;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_stream_arb #(.W_ADDR(22), .W_COUNT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_count0(req_count0), .req_count1(req_count1),
    .req_ready(req_ready), .done(done), .owner(owner), .owner_valid(owner_valid),
    .eng_addr_o(eng_addr_o), .eng_count_o(eng_count_o), .eng_wen(eng_wen),
    .eng_addr_i(eng_addr_i), .eng_count_i(eng_count_i),
    .eng_start(eng_start), .eng_pause_req(eng_pause_req),
    .eng_busy(eng_busy), .eng_pause_ack(eng_pause_ack),
    .eng_finished(eng_finished), .eng_flevel(eng_flevel)
  );

  typedef struct {
    logic [1:0]  v;
    logic        busy, fin;
    logic [1:0]  rdy, dn;
    logic        wen, st, ov, own;
    logic [21:0] ao;
    logic [15:0] co;
  } row_t;
  row_t rows[$];

  localparam logic [21:0] A0 = 22'h000200;
  localparam logic [15:0] C0 = 16'd4;
  localparam logic [21:0] A1 = 22'h000100;
  localparam logic [15:0] C1 = 16'd3;

  function automatic row_t mk(input logic [1:0] v, input logic busy, fin,
                              input logic [1:0] rdy, dn, input logic wen, st, ov, own,
                              input logic [21:0] ao, input logic [15:0] co);
    row_t r;
    r.v = v; r.busy = busy; r.fin = fin; r.rdy = rdy; r.dn = dn;
    r.wen = wen; r.st = st; r.ov = ov; r.own = own; r.ao = ao; r.co = co;
    return r;
  endfunction

  function automatic logic [63:0] pack(input logic [1:0] rdy, dn, input logic wen, st, pr, ov, own,
                                       input logic [21:0] ao, input logic [15:0] co);
    return {17'd0, rdy, dn, wen, st, pr, ov, own, ao, co};
  endfunction

  function automatic logic [63:0] outs();
    return {17'd0, req_ready, done, eng_wen, eng_start, eng_pause_req, owner_valid, owner,
            eng_addr_o, eng_count_o};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] v, input logic b, ack, fin, input logic [1:0] fl);
    req_valid = v; eng_busy = b; eng_pause_ack = ack; eng_finished = fin; eng_flevel = fl;
    #1;
  endtask

  // randomized-run state: producers, engine behaviour and transaction model
  logic [1:0]  pv;
  logic [21:0] pa[2];
  logic [15:0] pc[2];
  logic [21:0] pend_a;
  logic [15:0] pend_c;
  int          ph, pch, cur, e_delay, e_run, ndone;
  logic        seen, e_busy, e_fin;
  logic [63:0] exp_v;

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00; req_addr0 = A0; req_addr1 = A1; req_count0 = C0; req_count1 = C1;
    eng_addr_i = '0; eng_count_i = '0; eng_busy = 1'b0; eng_pause_ack = 1'b0;
    eng_finished = 1'b0; eng_flevel = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single ch1 descriptor, then simultaneous ch0/ch1 requests
    rows.push_back(mk(2'b10, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(2'b10, 0, 0, 2'b10, 2'b00, 1, 0, 0, 0, A1, C1));
    rows.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 0, 1, 1, 1, 0, 0));
    rows.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 0, 1, 1, 1, 0, 0));
    rows.push_back(mk(2'b00, 1, 0, 2'b00, 2'b00, 0, 1, 1, 1, 0, 0));
    rows.push_back(mk(2'b00, 1, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0));
    rows.push_back(mk(2'b00, 0, 1, 2'b00, 2'b10, 0, 0, 1, 1, 0, 0));
    rows.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(2'b11, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(2'b11, 0, 0, 2'b01, 2'b00, 1, 0, 0, 0, A0, C0));
    rows.push_back(mk(2'b10, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0, 0, 0));
    rows.push_back(mk(2'b10, 1, 0, 2'b00, 2'b00, 0, 1, 1, 0, 0, 0));
    rows.push_back(mk(2'b10, 0, 1, 2'b00, 2'b01, 0, 0, 1, 0, 0, 0));
    rows.push_back(mk(2'b10, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(2'b10, 0, 0, 2'b10, 2'b00, 1, 0, 0, 0, A1, C1));
    rows.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 0, 1, 1, 1, 0, 0));
    rows.push_back(mk(2'b00, 1, 0, 2'b00, 2'b00, 0, 1, 1, 1, 0, 0));
    rows.push_back(mk(2'b00, 0, 1, 2'b00, 2'b10, 0, 0, 1, 1, 0, 0));
    rows.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      drv(rows[i].v, rows[i].busy, 1'b0, rows[i].fin, 2'd0);
      chk($sformatf("row%0d", i), outs(),
          pack(rows[i].rdy, rows[i].dn, rows[i].wen, rows[i].st, 1'b0, rows[i].ov, rows[i].own,
               rows[i].ao, rows[i].co));
      tick();
    end

`ifdef SPI_STREAM_ARB_PREEMPT_EN
    // ch0 preempts a busy ch1; ch1 later resumes from the saved engine position
    req_count1 = 16'd15;
    drv(2'b10, 0, 0, 0, 0); chk("p_idle", outs(), 64'd0); tick();
    drv(2'b10, 0, 0, 0, 0); chk("p_load1", outs(), pack(2'b10, 0, 1, 0, 0, 0, 0, A1, 16'd15)); tick();
    drv(2'b00, 1, 0, 0, 0); chk("p_start1", outs(), pack(0, 0, 0, 1, 0, 1, 1, 0, 0)); tick();
    drv(2'b01, 1, 0, 0, 0); chk("p_run1", outs(), pack(0, 0, 0, 0, 0, 1, 1, 0, 0)); tick();
    drv(2'b01, 1, 0, 0, 2); chk("p_pause", outs(), pack(0, 0, 0, 0, 1, 1, 1, 0, 0)); tick();
    eng_addr_i = 22'h000105; eng_count_i = 16'd9;
    drv(2'b01, 1, 1, 0, 2); chk("p_ack", outs(), pack(0, 0, 0, 0, 1, 1, 1, 0, 0)); tick();
    eng_addr_i = 22'h3fffff; eng_count_i = 16'hffff;
    drv(2'b01, 1, 1, 0, 2); chk("p_drain_wait", outs(), pack(0, 0, 0, 0, 1, 1, 1, 0, 0)); tick();
    drv(2'b01, 1, 1, 0, 0); chk("p_drain_empty", outs(), pack(0, 0, 0, 0, 1, 1, 1, 0, 0)); tick();
    drv(2'b01, 1, 1, 0, 0); chk("p_swap", outs(), pack(2'b01, 0, 1, 0, 0, 1, 1, A0, C0)); tick();
    drv(2'b00, 1, 0, 0, 0); chk("p_run0", outs(), pack(0, 0, 0, 0, 0, 1, 0, 0, 0)); tick();
    drv(2'b00, 0, 0, 1, 0); chk("p_done0", outs(), pack(0, 2'b01, 0, 0, 0, 1, 0, 0, 0)); tick();
    drv(2'b00, 0, 0, 0, 0); chk("p_idle_ctx", outs(), 64'd0); tick();
    drv(2'b00, 0, 0, 0, 0); chk("p_reload", outs(), pack(0, 0, 1, 0, 0, 0, 0, 22'h000105, 16'd9)); tick();
    drv(2'b00, 1, 0, 0, 0); chk("p_start_ctx", outs(), pack(0, 0, 0, 1, 0, 1, 1, 0, 0)); tick();
    drv(2'b00, 0, 0, 1, 0); chk("p_done1", outs(), pack(0, 2'b10, 0, 0, 0, 1, 1, 0, 0)); tick();
    drv(2'b00, 0, 0, 0, 0); chk("p_idle_end", outs(), 64'd0); tick();
    drv(2'b00, 0, 0, 0, 0); chk("p_no_reload", outs(), 64'd0); tick();
    // ch1 finishes while the pause is pending: no context, ch0 goes through START
    drv(2'b10, 0, 0, 0, 0); chk("q_idle", outs(), 64'd0); tick();
    drv(2'b10, 0, 0, 0, 0); chk("q_load1", outs(), pack(2'b10, 0, 1, 0, 0, 0, 0, A1, 16'd15)); tick();
    drv(2'b00, 1, 0, 0, 0); chk("q_start1", outs(), pack(0, 0, 0, 1, 0, 1, 1, 0, 0)); tick();
    drv(2'b01, 1, 0, 0, 0); chk("q_run1", outs(), pack(0, 0, 0, 0, 0, 1, 1, 0, 0)); tick();
    drv(2'b01, 0, 0, 1, 0); chk("q_fin_in_pause", outs(), pack(0, 2'b10, 0, 0, 1, 1, 1, 0, 0)); tick();
    drv(2'b01, 0, 0, 0, 0); chk("q_drain", outs(), pack(0, 0, 0, 0, 1, 1, 1, 0, 0)); tick();
    drv(2'b01, 0, 0, 0, 0); chk("q_swap", outs(), pack(2'b01, 0, 1, 0, 0, 1, 1, A0, C0)); tick();
    drv(2'b00, 0, 0, 0, 0); chk("q_start0", outs(), pack(0, 0, 0, 1, 0, 1, 0, 0, 0)); tick();
    drv(2'b00, 1, 0, 0, 0); chk("q_start0_busy", outs(), pack(0, 0, 0, 1, 0, 1, 0, 0, 0)); tick();
    drv(2'b00, 0, 0, 1, 0); chk("q_done0", outs(), pack(0, 2'b01, 0, 0, 0, 1, 0, 0, 0)); tick();
    drv(2'b00, 0, 0, 0, 0); chk("q_idle_end", outs(), 64'd0); tick();
    drv(2'b00, 0, 0, 0, 0); chk("q_no_ctx", outs(), 64'd0); tick();
`endif

    // asynchronous reset in the middle of a ch0 transfer
    drv(2'b01, 0, 0, 0, 0); tick();
    drv(2'b00, 0, 0, 0, 0); tick();
    drv(2'b00, 1, 0, 0, 0); tick();
    drv(2'b00, 1, 0, 0, 0); chk("r_run", outs(), pack(0, 0, 0, 0, 0, 1, 0, 0, 0));
    rst_n = 1'b0;
    #1;
    chk("r_async_clear", outs(), 64'd0);
    tick(); tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      drv(2'b00, 0, 0, 1, 0);
      chk($sformatf("r_no_done%0d", i), outs(), 64'd0);
      tick();
    end

`ifndef SPI_STREAM_ARB_PREEMPT_EN
    // random producers and engine timing against a transaction-level model
    pv = 2'b00; ph = 0; pch = 0; cur = 0; seen = 1'b0; ndone = 0;
    e_busy = 1'b0; e_fin = 1'b0; e_delay = -1; e_run = 0;
    pend_a = '0; pend_c = '0;
    for (int c = 0; c < 2; c++) begin pa[c] = '0; pc[c] = '0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req_valid = pv; req_addr0 = pa[0]; req_addr1 = pa[1]; req_count0 = pc[0]; req_count1 = pc[1];
      eng_busy = e_busy; eng_finished = e_fin; eng_pause_ack = 1'b0;
      eng_flevel = 2'($urandom_range(0, 3)); eng_addr_i = 22'($urandom); eng_count_i = 16'($urandom);
      #1;
      exp_v = pack(ph == 1 ? 2'(1 << pch) : 2'b00, e_fin ? 2'(1 << cur) : 2'b00, ph == 1,
                   ph == 2 && !seen, 1'b0, ph == 2, ph == 2 ? cur[0] : 1'b0,
                   ph == 1 ? pend_a : 22'd0, ph == 1 ? pend_c : 16'd0);
      chk($sformatf("rand%0d", cyc), outs(), exp_v);
      if (e_fin) ndone++;
      if (ph == 1) begin
        ph = 2; cur = pch; seen = 1'b0;
      end else if (ph == 2) begin
        if (e_busy) seen = 1'b1;
        if (e_fin) ph = 0;
      end else if (pv != 2'b00) begin
        ph = 1; pch = pv[0] ? 0 : 1; pend_a = pa[pch]; pend_c = pc[pch];
      end
      for (int c = 0; c < 2; c++) begin
        if (pv[c] && req_ready[c]) pv[c] = 1'b0;
        else if (!pv[c] && $urandom_range(0, 3) == 0) begin
          pv[c] = 1'b1; pa[c] = 22'($urandom); pc[c] = 16'($urandom);
        end
      end
      if (e_fin) e_fin = 1'b0;
      else if (e_busy) begin
        if (e_run == 0) begin e_busy = 1'b0; e_fin = 1'b1; end
        else e_run--;
      end else if (eng_start) begin
        if (e_delay < 0) e_delay = $urandom_range(0, 2);
        if (e_delay == 0) begin e_busy = 1'b1; e_run = $urandom_range(0, 4); e_delay = -1; end
        else e_delay--;
      end
      tick();
    end
    chk("rand_progress", 64'(ndone > 50), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
